toggle_event_decoder: RTL and testbench
=======================================

// Module: toggle_event_decoder
// PURPOSE
//  Receive side of the toggle-encoded event link. The sender uses a T flip-flop
//  with t=1 for one cycle per event, so its q flips once per event.
//  This block detects every level change on that q, turns each one back into an
//  event, and queues pending events in a saturating counter.
//  Queued events are handed to the consumer through a valid/ready handshake.
//  It also reports a sticky overflow flag and a wrapping lifetime event count.
// PARAMETERS
//  MAX_PEND  7   max queued events; 1..255; count width CW = $clog2(MAX_PEND+1)
//  TOT_W     16  width of lifetime event counter ev_total
// PORTS
//  clk       in   1      rising-edge clock, single domain
//  reset     in   1      synchronous, active-high reset
//  tgl_in    in   1      toggle level from sender T flip-flop q
//  ev_ready  in   1      consumer accepts one event when ev_valid=1
//  ovf_clr   in   1      clears sticky overflow
//  ev_valid  out  1      at least one event pending (= pend != 0)
//  pend      out  CW     number of pending events
//  overflow  out  1      sticky: an event was dropped because the queue was full
//  ev_total  out  TOT_W  events detected since reset (includes dropped ones); wraps
//  lvl       out  1      last sampled toggle level (tgl_prev)
// BEHAVIOUR
//  - Reset (sync, clk edge with reset=1):
//    - outputs: pend=0, ev_valid=0, overflow=0, ev_total=0.
//    - tgl_prev and any sync stages load the current tgl_in.
//    - so lvl=tgl_in, and no event is generated from the level present at reset.
//  - Terms:
//    - tgl_s = sampled input: tgl_in, or the sync output when TOGGLE_SYNC_EN is set.
//    - edge = (tgl_s != tgl_prev).
//    - tgl_prev <= tgl_s every cycle.
//  - Detection:
//    - one event per level change, for both 0->1 and 1->0.
//    - a pulse narrower than one clk period may be missed. The sender guarantees
//      at most one flip per clk cycle; this is not checked.
//  - Handshake:
//    - pop = ev_valid & ev_ready.
//    - ev_valid depends only on registered pend; no combinational path from ev_ready.
//    - the consumer may hold ev_ready high; one event is taken per cycle.
//  - Queue update per clk edge:
//    - edge & !pop: pend+1 if pend<MAX_PEND; otherwise pend holds, the event is
//      dropped and overflow<=1.
//    - !edge & pop: pend-1.
//    - edge & pop: pend unchanged. This also applies at pend==MAX_PEND, so no drop.
//    - neither: hold.
//  - ev_total <= ev_total+1 on every edge, including dropped events; wraps modulo 2^TOT_W.
//  - overflow: set by a drop, cleared by ovf_clr. If both happen in the same cycle,
//    set wins and overflow=1.
//  - Latency (no sync):
//    - tgl_in flips before edge N -> pend and ev_valid update at edge N, so 1 cycle.
//    - event accepted at edge M -> pend drops at edge M.
//  - reset during activity: all pending events and the overflow flag are discarded.
//    The level present at reset is adopted and raises no event.
// CONFIGURATION
//  TOGGLE_SYNC_EN defined:
//   - adds a 2-flop synchronizer on tgl_in; tgl_s is the second stage.
//   - detection latency is 3 cycles (flip before edge N -> ev_valid after edge N+2).
//   - both stages load tgl_in on reset.
//  TOGGLE_SYNC_EN undefined:
//   - tgl_s = tgl_in directly.
//   - tgl_in must already be synchronous to clk.
//   - detection latency is 1 cycle.
// TESTING
//  1. tgl_in=1 held through reset -> after reset lvl=1, pend=0, ev_valid=0; no event over 5 cycles.
//  2. ev_ready=0; flip tgl_in 3 times, 2 cycles apart -> pend goes 1,2,3;
//     ev_total=3; overflow=0.
//  3. MAX_PEND=7, ev_ready=0, 9 flips -> pend saturates at 7; overflow=1;
//     ev_total=9. Pulse ovf_clr -> overflow=0.
//  4. pend=7, flip and ev_ready=1 in the same cycle -> pend stays 7, overflow
//     stays 0. Next cycle, with ev_ready=1 and no flip -> pend=6.
//  5. ev_ready=1 held, 4 flips one per cycle -> ev_valid high 1 cycle after the
//     first flip; pend stays 1 until the last flip; back to 0 one cycle after it.
//     Run with and without TOGGLE_SYNC_EN; latency must be 1 and 3 cycles respectively.
//  6. pend=4, reset asserted 1 cycle while tgl_in flips -> pend=0, overflow=0,
//     ev_total=0, lvl=new tgl_in level, no event raised.

Source files
------------

// File: rtl/toggle_event_decoder_if.sv
// Valid/ready event handshake between toggle_event_decoder (master) and its
// consumer (slave). pend width follows the decoder's MAX_PEND.
interface toggle_event_decoder_if #(
   parameter int unsigned MAX_PEND = 7
) ();
   localparam int unsigned CW = $clog2(MAX_PEND + 1);

   logic          ev_valid;
   logic          ev_ready;
   logic [CW-1:0] pend;

   modport master (output ev_valid, output pend, input ev_ready);
   modport slave  (input ev_valid, input pend, output ev_ready);
endinterface

// File: rtl/toggle_event_decoder.sv
// Receive side of a toggle-encoded event link. Every level change on tgl_in is
// turned back into one event and queued in a saturating counter that is drained
// through a valid/ready handshake. Also keeps a sticky overflow flag and a
// wrapping lifetime event count.
// Optional feature: define TOGGLE_SYNC_EN to add a 2-flop synchronizer on tgl_in.
module toggle_event_decoder #(
   parameter int unsigned MAX_PEND = 7,
   parameter int unsigned TOT_W    = 16
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   tgl_in,
   input  logic                   ovf_clr,
   toggle_event_decoder_if.master ev_if,
   output logic                   overflow,
   output logic [TOT_W-1:0]       ev_total,
   output logic                   lvl
);

   localparam int unsigned CW = $clog2(MAX_PEND + 1);
   localparam logic [CW-1:0] MaxPend = CW'(MAX_PEND);

   logic             tgl_s;
   logic             tgl_prev_q, tgl_prev_d;
   logic [CW-1:0]    pend_q, pend_d;
   logic             overflow_q, overflow_d;
   logic [TOT_W-1:0] ev_total_q, ev_total_d;
   logic             edge_det;
   logic             valid;
   logic             pop;

`ifdef TOGGLE_SYNC_EN
   logic sync1_q, sync1_d;
   logic sync2_q, sync2_d;

   // Synchronizer next state: plain two-stage shift.
   always_comb begin
      sync1_d = tgl_in;
      sync2_d = sync1_q;
   end

   // Both stages adopt the live level on reset so no stale edge survives it.
   always_ff @(posedge clk) begin
      if (reset) begin
         sync1_q <= tgl_in;
         sync2_q <= tgl_in;
      end else begin
         sync1_q <= sync1_d;
         sync2_q <= sync2_d;
      end
   end

   assign tgl_s = sync2_q;
`else
   assign tgl_s = tgl_in;
`endif

   // Edge detection, handshake pop and queue/overflow/total next state.
   always_comb begin
      valid      = (pend_q != '0);
      edge_det   = tgl_s ^ tgl_prev_q;
      pop        = valid & ev_if.ev_ready;
      tgl_prev_d = tgl_s;
      pend_d     = pend_q;
      overflow_d = overflow_q & ~ovf_clr;
      ev_total_d = ev_total_q + TOT_W'(edge_det);
      if (edge_det && !pop) begin
         if (pend_q < MaxPend) begin
            pend_d = pend_q + CW'(1);
         end else begin
            // Queue full: event is dropped; set beats a simultaneous clear.
            overflow_d = 1'b1;
         end
      end else if (!edge_det && pop) begin
         pend_d = pend_q - CW'(1);
      end
   end

   // State registers; the level present at reset is adopted without an event.
   always_ff @(posedge clk) begin
      if (reset) begin
         tgl_prev_q <= tgl_in;
         pend_q     <= '0;
         overflow_q <= 1'b0;
         ev_total_q <= '0;
      end else begin
         tgl_prev_q <= tgl_prev_d;
         pend_q     <= pend_d;
         overflow_q <= overflow_d;
         ev_total_q <= ev_total_d;
      end
   end

   assign ev_if.ev_valid = valid;
   assign ev_if.pend     = pend_q;
   assign overflow       = overflow_q;
   assign ev_total       = ev_total_q;
   assign lvl            = tgl_prev_q;

endmodule

// File: tb/tb_toggle_event_decoder.sv
// Self-checking bench for toggle_event_decoder: cycle-level event-count model
// plus directed checks with hand-computed values. Honours TOGGLE_SYNC_EN.
module tb_toggle_event_decoder;

   localparam int unsigned MAX_PEND = 7;
   localparam int unsigned TOT_W    = 16;
   localparam int unsigned CW       = $clog2(MAX_PEND + 1);
`ifdef TOGGLE_SYNC_EN
   localparam int LAT = 3;
`else
   localparam int LAT = 1;
`endif

   logic             clk;
   logic             reset;
   logic             tgl_in;
   logic             ovf_clr;
   logic             overflow;
   logic [TOT_W-1:0] ev_total;
   logic             lvl;

   toggle_event_decoder_if #(.MAX_PEND(MAX_PEND)) ifc ();

   toggle_event_decoder #(
      .MAX_PEND(MAX_PEND),
      .TOT_W   (TOT_W)
   ) dut (
      .clk     (clk),
      .reset   (reset),
      .tgl_in  (tgl_in),
      .ovf_clr (ovf_clr),
      .ev_if   (ifc.master),
      .overflow(overflow),
      .ev_total(ev_total),
      .lvl     (lvl)
   );

   int n_total = 0;
   int n_bad   = 0;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Model state: events counted as integers, input history for the sync delay.
   bit m_h0, m_h1;
   bit m_lvl;
   int m_pend, m_tot;
   bit m_ovf;
   bit chk_en = 1'b0;

   always @(posedge clk) begin : model
      bit ts;
      int ed, pp, np, drop;
      if (reset) begin
         m_h0   <= tgl_in;
         m_h1   <= tgl_in;
         m_lvl  <= tgl_in;
         m_pend <= 0;
         m_tot  <= 0;
         m_ovf  <= 1'b0;
         chk_en <= 1'b1;
      end else begin
`ifdef TOGGLE_SYNC_EN
         ts = m_h1;
`else
         ts = tgl_in;
`endif
         ed   = (ts != m_lvl) ? 1 : 0;
         pp   = (m_pend > 0 && ifc.ev_ready) ? 1 : 0;
         np   = m_pend + ed - pp;
         drop = (np > int'(MAX_PEND)) ? 1 : 0;
         if (drop != 0) np = MAX_PEND;
         m_pend <= np;
         m_tot  <= (m_tot + ed) % (1 << TOT_W);
         m_ovf  <= (drop != 0) || (m_ovf && !ovf_clr);
         m_lvl  <= ts;
         m_h0   <= tgl_in;
         m_h1   <= m_h0;
      end
   end

   // Every-cycle comparison of all outputs against the model.
   always @(negedge clk) begin
      if (chk_en) begin
         n_total++;
         if (ifc.pend !== CW'(m_pend) || ifc.ev_valid !== (m_pend != 0) ||
             overflow !== m_ovf || ev_total !== TOT_W'(m_tot) || lvl !== m_lvl) begin
            n_bad++;
            $display("FAIL model t=%0t got pend=%0d vld=%0b ovf=%0b tot=%0d lvl=%0b exp pend=%0d vld=%0b ovf=%0b tot=%0d lvl=%0b",
                     $time, ifc.pend, ifc.ev_valid, overflow, ev_total, lvl,
                     m_pend, (m_pend != 0), m_ovf, m_tot, m_lvl);
         end
      end
   end

   task automatic chk(input string name, input int got, input int exp);
      n_total++;
      if (got != exp) begin
         n_bad++;
         $display("FAIL %s got=%0d exp=%0d", name, got, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic flip();
      tgl_in = ~tgl_in;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      tick(1);
      reset = 1'b0;
   endtask

   initial begin
      tgl_in       = 1'b1;
      reset        = 1'b1;
      ovf_clr      = 1'b0;
      ifc.ev_ready = 1'b0;

      // 1: level held through reset is adopted, no event
      tick(2);
      reset = 1'b0;
      chk("t1_lvl", int'(lvl), 1);
      chk("t1_pend", int'(ifc.pend), 0);
      chk("t1_valid", int'(ifc.ev_valid), 0);
      tick(5);
      chk("t1_pend_later", int'(ifc.pend), 0);
      chk("t1_total", int'(ev_total), 0);

      // 2: three flips, no consumer
      for (int i = 0; i < 3; i++) begin
         flip();
         tick(LAT);
         chk("t2_pend", int'(ifc.pend), i + 1);
         tick(1);
      end
      chk("t2_total", int'(ev_total), 3);
      chk("t2_ovf", int'(overflow), 0);

      // 3: saturation and overflow, then clear
      do_reset();
      for (int i = 0; i < 9; i++) begin
         flip();
         tick(1);
      end
      tick(LAT);
      chk("t3_pend_sat", int'(ifc.pend), 7);
      chk("t3_ovf", int'(overflow), 1);
      chk("t3_total", int'(ev_total), 9);
      ovf_clr = 1'b1;
      tick(1);
      ovf_clr = 1'b0;
      chk("t3_ovf_clr", int'(overflow), 0);

      // 4: full queue, edge and pop on the same cycle: no drop
      flip();
      if (LAT > 1) tick(LAT - 1);
      ifc.ev_ready = 1'b1;
      tick(1);
      chk("t4_pend_full", int'(ifc.pend), 7);
      chk("t4_ovf", int'(overflow), 0);
      tick(1);
      chk("t4_pend_pop", int'(ifc.pend), 6);
      ifc.ev_ready = 1'b0;

      // 5: consumer always ready, four back-to-back flips
      do_reset();
      ifc.ev_ready = 1'b1;
      chk("t5_pend0", int'(ifc.pend), 0);
      for (int t = 1; t <= 8; t++) begin
         if (t <= 4) flip();
         tick(1);
         chk("t5_valid", int'(ifc.ev_valid), (t >= LAT && t <= LAT + 3) ? 1 : 0);
      end
      chk("t5_total", int'(ev_total), 4);
      ifc.ev_ready = 1'b0;

      // 6: reset with events pending while tgl_in flips
      do_reset();
      for (int i = 0; i < 4; i++) begin
         flip();
         tick(1);
      end
      tick(LAT);
      chk("t6_pend4", int'(ifc.pend), 4);
      reset = 1'b1;
      flip();
      tick(1);
      reset = 1'b0;
      chk("t6_pend", int'(ifc.pend), 0);
      chk("t6_ovf", int'(overflow), 0);
      chk("t6_total", int'(ev_total), 0);
      chk("t6_lvl", int'(lvl), int'(tgl_in));
      tick(5);
      chk("t6_no_event", int'(ifc.pend), 0);
      chk("t6_total_later", int'(ev_total), 0);

      tick(2);
      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule
